// File: rtl/gmac_fifo_pkg.sv
// Shared definitions for the GMAC transmit frame FIFO: write-FSM states
// and the default geometry used by the FIFO and its storage.
package gmac_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_BITS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2
    } wstate_t;

    function automatic int depth_of(input int addr_bits);
        return 1 << addr_bits;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Entry storage for the frame FIFO: synchronous write, asynchronous read.
module fifo_mem
    import gmac_fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_DATA_WIDTH + 1,
    parameter int ADDR_BITS = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    localparam int DEPTH = depth_of(ADDR_BITS);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tx_frame_fifo.sv
// Store-and-forward transmit frame FIFO: a frame becomes readable only once its
// last beat is committed; errored or oversized frames are rewound and dropped.
module tx_frame_fifo
    import gmac_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int AFULL_LEVEL = depth_of(ADDR_BITS) - 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wlast,
    input  logic                  werr,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rlast,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_BITS:0]    level,
    output logic [ADDR_BITS:0]    frame_count,
    output logic                  drop
);

    localparam int PW    = ADDR_BITS + 1;
    localparam int DEPTH = depth_of(ADDR_BITS);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_P = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    wstate_t       state, state_nxt;
    logic [PW-1:0] rd_ptr, wr_cur, wr_commit;
    logic [PW-1:0] wr_cur_nxt, wr_commit_nxt;
    logic [PW-1:0] span;
    logic          drop_nxt;
    logic          wfire, rfire, mem_we, commit, overflow;
    logic [DATA_WIDTH:0] mem_rdata;

    // Occupancy counts uncommitted beats; the extra pointer MSB separates full from empty.
    assign level       = wr_cur - rd_ptr;
    assign span        = wr_cur - wr_commit;
    assign full        = (wr_cur[ADDR_BITS] != rd_ptr[ADDR_BITS]) &&
                         (wr_cur[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
    assign empty       = (wr_cur == rd_ptr);
    assign almost_full = (level >= AFULL_P);

    // An open frame spanning the whole memory can never commit, so it is abandoned.
    assign overflow = (state == ST_FRAME) && (span == DEPTH_P);

    assign wready = (state == ST_DROP) ? 1'b1 : !full;
    assign wfire  = wvalid && wready;
    assign mem_we = wfire && (state != ST_DROP) && !(wlast && werr);
    assign commit = mem_we && wlast;

    assign rvalid = (frame_count != '0);
    assign rfire  = rvalid && rready;
    assign rdata  = mem_rdata[DATA_WIDTH-1:0];
    assign rlast  = mem_rdata[DATA_WIDTH];

    fifo_mem #(
        .WIDTH     (DATA_WIDTH + 1),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_cur[ADDR_BITS-1:0]),
        .wdata ({wlast, wdata}),
        .raddr (rd_ptr[ADDR_BITS-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_nxt     = state;
        wr_cur_nxt    = wr_cur;
        wr_commit_nxt = wr_commit;
        drop_nxt      = 1'b0;
        if (state == ST_DROP) begin
            if (wfire && wlast) begin
                drop_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
        end else if (overflow) begin
            wr_cur_nxt = wr_commit;
            state_nxt  = ST_DROP;
        end else if (wfire) begin
            if (wlast && werr) begin
                wr_cur_nxt = wr_commit;
                drop_nxt   = 1'b1;
                state_nxt  = ST_IDLE;
            end else if (wlast) begin
                wr_cur_nxt    = wr_cur + ONE_P;
                wr_commit_nxt = wr_cur + ONE_P;
                state_nxt     = ST_IDLE;
            end else begin
                wr_cur_nxt = wr_cur + ONE_P;
                state_nxt  = ST_FRAME;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            wr_cur      <= '0;
            wr_commit   <= '0;
            rd_ptr      <= '0;
            frame_count <= '0;
            drop        <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_cur    <= wr_cur_nxt;
            wr_commit <= wr_commit_nxt;
            drop      <= drop_nxt;
            if (rfire) begin
                rd_ptr <= rd_ptr + ONE_P;
            end
            // A commit and a frame-ending read in the same cycle cancel out.
            case ({commit, rfire && rlast})
                2'b10:   frame_count <= frame_count + ONE_P;
                2'b01:   frame_count <= frame_count - ONE_P;
                default: frame_count <= frame_count;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_fifo.sv
// Directed bench for tx_frame_fifo (DATA_WIDTH=8, ADDR_BITS=4).
module tb_tx_frame_fifo;

    logic       clk = 1'b0;
    logic       rstn;
    logic       wvalid, wready, wlast, werr;
    logic [7:0] wdata;
    logic       rvalid, rready, rlast;
    logic [7:0] rdata;
    logic       full, empty, almost_full, drop;
    logic [4:0] level, frame_count;

    int errors = 0;
    int checks = 0;

    tx_frame_fifo #(
        .DATA_WIDTH  (8),
        .ADDR_BITS   (4),
        .AFULL_LEVEL (14)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wvalid      (wvalid),
        .wready      (wready),
        .wdata       (wdata),
        .wlast       (wlast),
        .werr        (werr),
        .rvalid      (rvalid),
        .rready      (rready),
        .rdata       (rdata),
        .rlast       (rlast),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .level       (level),
        .frame_count (frame_count),
        .drop        (drop)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic last, input logic err);
        wvalid = 1'b1;
        wdata  = d;
        wlast  = last;
        werr   = err;
    endtask

    task automatic idle_w();
        wvalid = 1'b0;
        wlast  = 1'b0;
        werr   = 1'b0;
        wdata  = 8'h00;
    endtask

    initial begin
        rstn = 1'b0;
        rready = 1'b0;
        idle_w();
        #3;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_level", level, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_fcount", frame_count, 0);
        check("rst_drop", drop, 0);
        check("rst_wready", wready, 1);
        #9;
        rstn = 1'b1;

        // 5-beat frame, store-and-forward
        rready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            beat(8'(i), i == 5, 1'b0);
            check($sformatf("sf_rvalid_pre%0d", i), rvalid, 0);
            tick();
        end
        idle_w();
        check("sf_fcount1", frame_count, 1);
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("sf_rvalid%0d", i), rvalid, 1);
            check($sformatf("sf_rdata%0d", i), rdata, i);
            check($sformatf("sf_rlast%0d", i), rlast, (i == 5) ? 1 : 0);
            tick();
        end
        check("sf_fcount0", frame_count, 0);
        check("sf_empty", empty, 1);
        check("sf_rvalid_end", rvalid, 0);

        // errored 3-beat frame
        for (int i = 1; i <= 3; i++) begin
            beat(8'(8'h40 + i), i == 3, i == 3);
            tick();
            if (i < 3) check($sformatf("err_level%0d", i), level, i);
            check($sformatf("err_rvalid%0d", i), rvalid, 0);
        end
        idle_w();
        check("err_drop", drop, 1);
        check("err_level0", level, 0);
        tick();
        check("err_drop_once", drop, 0);
        check("err_rvalid_end", rvalid, 0);

        // 20-beat frame cannot fit: dropped, then a short frame passes
        for (int i = 1; i <= 16; i++) begin
            beat(8'(i), 1'b0, 1'b0);
            check($sformatf("ovf_wready%0d", i), wready, 1);
            tick();
        end
        beat(8'd17, 1'b0, 1'b0);
        check("ovf_full", full, 1);
        check("ovf_wready_stall", wready, 0);
        check("ovf_level16", level, 16);
        check("ovf_rvalid", rvalid, 0);
        tick();
        check("ovf_drop_level", level, 0);
        check("ovf_drop_empty", empty, 1);
        for (int i = 17; i <= 20; i++) begin
            beat(8'(i), i == 20, 1'b0);
            check($sformatf("ovf_wready%0d", i), wready, 1);
            check($sformatf("ovf_nodrop%0d", i), drop, 0);
            tick();
        end
        check("ovf_drop", drop, 1);
        check("ovf_level_after", level, 0);
        check("ovf_rvalid_after", rvalid, 0);
        beat(8'hA1, 1'b0, 1'b0);
        tick();
        check("ovf_drop_once", drop, 0);
        beat(8'hA2, 1'b1, 1'b0);
        tick();
        idle_w();
        check("post_rvalid", rvalid, 1);
        check("post_rdata1", rdata, 8'hA1);
        check("post_rlast1", rlast, 0);
        tick();
        check("post_rdata2", rdata, 8'hA2);
        check("post_rlast2", rlast, 1);
        tick();
        check("post_empty", empty, 1);
        check("post_fcount", frame_count, 0);

        // fill to full with one committed frame and one open frame
        rready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            beat(8'(8'h10 + i), i == 9, 1'b0);
            tick();
        end
        check("fill_fcount", frame_count, 1);
        check("fill_level10", level, 10);
        for (int k = 0; k < 6; k++) begin
            beat(8'(8'h20 + k), 1'b0, 1'b0);
            tick();
            check($sformatf("fill_level%0d", 11 + k), level, 11 + k);
            if (k == 2) check("fill_afull13", almost_full, 0);
            if (k == 3) check("fill_afull14", almost_full, 1);
        end
        beat(8'h26, 1'b0, 1'b0);
        check("fill_full", full, 1);
        check("fill_wready", wready, 0);
        check("fill_afull16", almost_full, 1);
        tick();
        check("stall_level", level, 16);
        check("stall_full", full, 1);
        rready = 1'b1;
        check("rd_rvalid", rvalid, 1);
        check("rd_rdata", rdata, 8'h10);
        tick();
        idle_w();
        check("rd_wready", wready, 1);
        check("rd_full", full, 0);
        check("rd_level15", level, 15);

        // frame B commit coincides with frame A rlast
        for (int j = 1; j <= 8; j++) begin
            check($sformatf("a_rdata%0d", j), rdata, 8'h10 + j);
            check($sformatf("a_rlast%0d", j), rlast, 0);
            tick();
        end
        check("a_rdata_last", rdata, 8'h19);
        check("a_rlast", rlast, 1);
        check("a_fcount", frame_count, 1);
        check("a_level7", level, 7);
        beat(8'h26, 1'b1, 1'b0);
        tick();
        idle_w();
        check("coinc_fcount", frame_count, 1);
        check("coinc_level", level, 7);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("b_rdata%0d", k), rdata, 8'h20 + k);
            check($sformatf("b_rlast%0d", k), rlast, (k == 6) ? 1 : 0);
            tick();
        end
        check("b_fcount0", frame_count, 0);
        check("b_empty", empty, 1);

        // async reset mid-frame with one committed frame
        rready = 1'b0;
        beat(8'h31, 1'b0, 1'b0);
        tick();
        beat(8'h32, 1'b1, 1'b0);
        tick();
        beat(8'h33, 1'b0, 1'b0);
        tick();
        idle_w();
        check("pre_rst_fcount", frame_count, 1);
        check("pre_rst_level", level, 3);
        #1;
        rstn = 1'b0;
        #1;
        check("mid_rst_empty", empty, 1);
        check("mid_rst_fcount", frame_count, 0);
        check("mid_rst_drop", drop, 0);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_level", level, 0);
        #1;
        rstn = 1'b1;
        tick();
        check("after_rst_drop", drop, 0);
        beat(8'h44, 1'b1, 1'b0);
        tick();
        idle_w();
        rready = 1'b1;
        check("after_rst_rvalid", rvalid, 1);
        check("after_rst_rdata", rdata, 8'h44);
        check("after_rst_rlast", rlast, 1);
        check("after_rst_level", level, 1);
        tick();
        check("after_rst_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_frame_fifo.md
TX_FRAME_FIFO -- requirements
Module: tx_frame_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload bits per beat.
REQ-002 SHALL have parameter ADDR_BITS, default 4: DEPTH = 2**ADDR_BITS entries.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-2: almost_full threshold in entries.
REQ-004 SHALL have one clock, clk; reset is asynchronous and active-low, rstn.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rstn  in  1  async active-low reset
- wvalid  in  1  write beat valid
- wready  out  1  write beat accepted when wvalid & wready
- wdata  in  DATA_WIDTH  write payload
- wlast  in  1  last beat of frame
- werr  in  1  frame bad; sampled only with wlast
- rvalid  out  1  read beat available
- rready  in  1  read beat consumed when rvalid & rready
- rdata  out  DATA_WIDTH  read payload
- rlast  out  1  last beat of frame
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- almost_full  out  1  occupancy >= AFULL_LEVEL
- level  out  ADDR_BITS+1  occupancy, including uncommitted beats
- frame_count  out  ADDR_BITS+1  committed frames not yet fully read
- drop  out  1  one-cycle pulse: frame discarded

Function
REQ-006 SHALL operate store-and-forward: rvalid = (frame_count != 0); beats of an uncommitted frame are never presented.
REQ-007 SHALL keep three ADDR_BITS+1-bit pointers: rd_ptr, wr_cur (next write) and wr_commit (start of open frame); occupancy = wr_cur - rd_ptr, modulo 2**(ADDR_BITS+1).
REQ-008 SHALL store {wlast, wdata} per entry; rdata/rlast SHALL be combinational reads at rd_ptr (first-word-fall-through, zero read latency).
REQ-009 Write FSM SHALL have states IDLE (no open frame), FRAME (open frame), DROP (discarding).
REQ-010 IDLE/FRAME: wready = !full; accepted non-last beat -> write, wr_cur+1, state FRAME.
REQ-011 Accepted wlast with werr=0 SHALL write, set wr_commit = wr_cur+1, frame_count+1 (visible next cycle), state IDLE.
REQ-012 Accepted wlast with werr=1 SHALL set wr_cur = wr_commit (rewind), drop=1 next cycle, state IDLE.
REQ-013 In FRAME, when wr_cur - wr_commit reaches DEPTH (frame cannot fit), the FSM SHALL rewind wr_cur = wr_commit and enter DROP.
REQ-014 DROP: wready = 1, beats are discarded; accepted wlast -> drop=1 next cycle, state IDLE.
REQ-015 Read: accepted beat -> rd_ptr+1; accepted beat with rlast -> frame_count-1.
REQ-016 Commit and rlast read in the same cycle SHALL leave frame_count unchanged; write and read in the same cycle SHALL leave level unchanged.
REQ-017 Pointer wrap SHALL be natural binary overflow; full/empty SHALL use the extra MSB.
REQ-018 rready while rvalid=0 SHALL have no effect; wvalid with full (not DROP) SHALL stall with no state change.

Reset
REQ-019 rstn low SHALL asynchronously clear all pointers and frame_count, set state IDLE, drop=0; hence empty=1, full=0, almost_full=0, level=0, rvalid=0.
REQ-020 Reset mid-frame SHALL discard all content, committed or not; no drop pulse.
REQ-021 Memory contents SHALL not be reset.

Structure
REQ-022 Shared package gmac_fifo_pkg SHALL hold the write-FSM state enum and DEPTH/width helper constants.
REQ-023 Storage SHALL be one sub-module, fifo_mem (register array, synchronous write, asynchronous read, DATA_WIDTH+1 wide); all control SHALL be in tx_frame_fifo.

Verification (DATA_WIDTH=8, ADDR_BITS=4)
REQ-024 5-beat frame 0x01..0x05, rready=1 -> rvalid stays 0 until the cycle after wlast; then 0x01..0x05 on consecutive cycles, rlast on 0x05; frame_count 1->0.
REQ-025 3-beat frame, werr=1 on wlast -> drop pulses once, level returns to 0, rvalid never asserts.
REQ-026 Empty FIFO, 20-beat frame -> after beat 16, state DROP with level 0; beats 17-20 are accepted (wready=1); drop pulses after beat 20; a following 2-beat frame is read intact.
REQ-027 Commit 10-beat frame, then write 6 beats of frame 2 with rready=0 -> full=1, wready=0, almost_full=1 (from level 14); one read -> wready=1 next cycle.
REQ-028 Frame B's wlast commit coincides with frame A's rlast read -> frame_count holds 1, B then reads correctly.
REQ-029 rstn pulsed mid-frame with one committed frame -> empty=1, frame_count=0, drop=0, rvalid=0 immediately.
